sd_cmd_sequencer: RTL and testbench
===================================

Name: sd_cmd_sequencer

Overview:
Sequences a complete SD-card SPI-mode command transaction. It builds the 48-bit command frame and drives a bit-serial CRC7 unit over the first 40 bits. It then streams the 6 frame bytes to the SPI byte engine and polls for the R1 response. It sits between the SD init/read FSM (command requester) and the full-duplex SPI byte engine, and owns the CRC7 datapath.

Parameters:
RESP_TIMEOUT, 8, max number of 0xFF poll bytes (Ncr) before declaring timeout; legal 1..255
POLL_BYTE, 8'hFF, byte transmitted while polling for R1

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
start  in  1  request pulse; sampled only in IDLE
cmd_idx  in  6  SD command index, captured on accepted start
cmd_arg  in  32  command argument, captured on accepted start
busy  out  1  high from accepted start until done cycle inclusive
done  out  1  one-cycle pulse at transaction end
resp  out  8  R1 response byte; valid when done is high, held until next start
timeout  out  1  set with done when no R1 arrived; held until next start
tx_byte  out  8  byte to SPI engine
tx_valid  out  1  byte offered to SPI engine
tx_ready  in  1  SPI engine accepts tx_byte when tx_valid and tx_ready are both high
rx_byte  in  8  byte shifted in by the SPI engine
rx_valid  in  1  one-cycle pulse; exactly one per accepted tx byte

Behaviour:
- Reset: state IDLE; busy=0, done=0, resp=8'hFF, timeout=0, tx_valid=0, tx_byte=8'hFF; CRC register cleared. Reset mid-transaction aborts immediately. No tx_valid is asserted in the cycle after reset.
- Frame layout: {2'b01, cmd_idx, cmd_arg, crc7, 1'b1}. CRC7 polynomial is x^7+x^3+1, initial value 0, computed MSB-first over the first 40 bits.
- IDLE: start=1 captures cmd_idx/cmd_arg into a 40-bit shift register, clears CRC, sets busy, and moves to CRC.
- CRC: one bit per clock, MSB first, for exactly 40 clocks (6-bit counter 0..39), then moves to SEND.
- SEND: bytes 0..5 in order. tx_valid is first high 42 clocks after the clock edge that accepted start.
- Handshake rules:
  - tx_valid and tx_byte stay stable until the tx_ready handshake.
  - After a handshake, tx_valid drops and the block waits for rx_valid before offering the next byte. At most one byte is outstanding.
  - rx bytes received during SEND are discarded.
  - After the rx_valid for byte 5, the block moves to POLL.
- POLL: sends POLL_BYTE using the same one-outstanding handshake.
  - On each rx_valid with rx_byte[7]==0: resp<=rx_byte, timeout<=0, move to DONE.
  - Otherwise the poll counter increments. When the counter reaches RESP_TIMEOUT: resp<=8'hFF, timeout<=1, move to DONE. No extra poll byte is sent.
- DONE: done=1 for one cycle, busy=1 in that cycle, then IDLE. A start arriving in the DONE cycle is ignored.
- start while busy is ignored; captured command fields are not disturbed.
- rx_valid with no outstanding byte (protocol violation) is ignored.
- tx_ready held high continuously: one byte per rx round trip, no duplicates.
- The block never deasserts chip select; the requester owns CS.

Decomposition:
- Package sd_spi_pkg holds:
  - CRC7_POLY=7'h09
  - CMD_START=2'b01, CMD_STOP=1'b1
  - IDLE_BYTE=8'hFF
  - FRAME_BITS=48, CRC_BITS=40
  - state enum {IDLE, CRC, SEND, POLL, DONE}
- One sub-module, crc7_serial, with ports clk, reset, clr, en, bit_in, crc[6:0]:
  - crc <= {crc[5:0],0} ^ (fb ? 7'h09 : 0), where fb = bit_in ^ crc[6]
  - sync active-high reset; clr has priority over en.

Test Plan:
- CMD0, arg 0; byte engine echoes with 1-cycle latency and rx 0xFF,0x01 in POLL -> tx bytes 40 00 00 00 00 95, then FF FF; resp=0x01, timeout=0, done pulse once.
- CMD8, arg 32'h000001AA; R1 0x01 on first poll -> tx bytes 48 00 00 01 AA 87; first tx_valid exactly 42 clocks after start.
- CMD0 with rx always 0xFF -> exactly 8 poll bytes sent; resp=0xFF, timeout=1, busy low the cycle after done.
- Random tx_ready stalls (0-5 cycles) on CMD8 -> tx_byte/tx_valid stable while stalled; byte sequence identical to the unstalled case.
- start pulsed during SEND with a different cmd_idx -> ignored; the original frame completes unchanged.
- reset asserted mid-SEND (after byte 2) -> next cycle IDLE, tx_valid=0, busy=0, resp=0xFF; a fresh CMD0 then completes normally.

Source files
------------

// File: rtl/sd_spi_pkg.sv
// Shared constants and state encoding for the SD SPI-mode command path.
// Frame layout is {start bits, index, argument, crc7, stop bit}.
package sd_spi_pkg;

    localparam logic [6:0]  CRC7_POLY  = 7'h09;
    localparam logic [1:0]  CMD_START  = 2'b01;
    localparam logic        CMD_STOP   = 1'b1;
    localparam logic [7:0]  IDLE_BYTE  = 8'hFF;
    localparam int unsigned FRAME_BITS = 48;
    localparam int unsigned CRC_BITS   = 40;

    typedef enum logic [2:0] {
        IDLE,
        CRC,
        SEND,
        POLL,
        DONE
    } seq_state_e;

endpackage

// File: rtl/crc7_serial.sv
// Bit-serial CRC7 (x^7 + x^3 + 1), MSB-first, zero initial value.
// clr takes priority over en so a new frame can start on any cycle.
module crc7_serial
    import sd_spi_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       clr,
    input  logic       en,
    input  logic       bit_in,
    output logic [6:0] crc
);

    logic fb;

    assign fb = bit_in ^ crc[6];

    always_ff @(posedge clk) begin
        if (reset) begin
            crc <= '0;
        end else if (clr) begin
            crc <= '0;
        end else if (en) begin
            crc <= {crc[5:0], 1'b0} ^ (fb ? CRC7_POLY : 7'h00);
        end
    end

endmodule

// File: rtl/sd_cmd_sequencer.sv
// Builds an SD SPI-mode command frame, streams it to the byte engine with at most one
// byte outstanding, then polls for the R1 response byte or gives up after RESP_TIMEOUT polls.
module sd_cmd_sequencer
    import sd_spi_pkg::*;
#(
    parameter int unsigned RESP_TIMEOUT = 8,
    parameter logic [7:0]  POLL_BYTE    = 8'hFF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [5:0]  cmd_idx,
    input  logic [31:0] cmd_arg,
    output logic        busy,
    output logic        done,
    output logic [7:0]  resp,
    output logic        timeout,
    output logic [7:0]  tx_byte,
    output logic        tx_valid,
    input  logic        tx_ready,
    input  logic [7:0]  rx_byte,
    input  logic        rx_valid
);

    localparam logic [5:0] LAST_BIT  = 6'(CRC_BITS - 1);
    localparam logic [2:0] LAST_BYTE = 3'(FRAME_BITS / 8 - 1);
    localparam logic [7:0] LAST_POLL = 8'(RESP_TIMEOUT - 1);

    seq_state_e            state_q;
    logic [CRC_BITS-1:0]   shreg_q;
    logic [5:0]            bit_cnt_q;
    logic [FRAME_BITS-1:0] frame_q;
    logic                  frame_rdy_q;
    logic [2:0]            byte_cnt_q;
    logic [7:0]            poll_cnt_q;
    logic                  outstanding_q;

    logic       crc_clr;
    logic       crc_en;
    logic [6:0] crc_val;
    logic       can_offer;
    logic       hs;
    logic       rx_hit;

    assign crc_clr   = (state_q == IDLE) && start;
    assign crc_en    = (state_q == CRC);
    assign can_offer = !tx_valid && !outstanding_q;
    assign hs        = tx_valid && tx_ready;
    // An rx pulse only counts when it answers a byte we actually handed off.
    assign rx_hit    = outstanding_q && rx_valid;

    crc7_serial u_crc7 (
        .clk    (clk),
        .reset  (reset),
        .clr    (crc_clr),
        .en     (crc_en),
        .bit_in (shreg_q[CRC_BITS-1]),
        .crc    (crc_val)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= IDLE;
            busy          <= 1'b0;
            done          <= 1'b0;
            resp          <= IDLE_BYTE;
            timeout       <= 1'b0;
            tx_valid      <= 1'b0;
            tx_byte       <= IDLE_BYTE;
            shreg_q       <= '0;
            bit_cnt_q     <= '0;
            frame_q       <= '0;
            frame_rdy_q   <= 1'b0;
            byte_cnt_q    <= '0;
            poll_cnt_q    <= '0;
            outstanding_q <= 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (start) begin
                        shreg_q   <= {CMD_START, cmd_idx, cmd_arg};
                        bit_cnt_q <= '0;
                        busy      <= 1'b1;
                        resp      <= IDLE_BYTE;
                        timeout   <= 1'b0;
                        state_q   <= CRC;
                    end
                end

                CRC: begin
                    // Rotate rather than shift so the header is intact after the last bit.
                    shreg_q <= {shreg_q[CRC_BITS-2:0], shreg_q[CRC_BITS-1]};
                    if (bit_cnt_q == LAST_BIT) begin
                        frame_rdy_q <= 1'b0;
                        byte_cnt_q  <= '0;
                        state_q     <= SEND;
                    end else begin
                        bit_cnt_q <= bit_cnt_q + 6'd1;
                    end
                end

                SEND: begin
                    if (!frame_rdy_q) begin
                        frame_q     <= {shreg_q, crc_val, CMD_STOP};
                        frame_rdy_q <= 1'b1;
                    end else if (can_offer) begin
                        tx_byte  <= frame_q[FRAME_BITS-1 -: 8];
                        tx_valid <= 1'b1;
                        frame_q  <= {frame_q[FRAME_BITS-9:0], IDLE_BYTE};
                    end
                    if (hs) begin
                        tx_valid      <= 1'b0;
                        outstanding_q <= 1'b1;
                    end
                    if (rx_hit) begin
                        outstanding_q <= 1'b0;
                        if (byte_cnt_q == LAST_BYTE) begin
                            poll_cnt_q <= '0;
                            state_q    <= POLL;
                        end else begin
                            byte_cnt_q <= byte_cnt_q + 3'd1;
                        end
                    end
                end

                POLL: begin
                    if (can_offer) begin
                        tx_byte  <= POLL_BYTE;
                        tx_valid <= 1'b1;
                    end
                    if (hs) begin
                        tx_valid      <= 1'b0;
                        outstanding_q <= 1'b1;
                    end
                    if (rx_hit) begin
                        outstanding_q <= 1'b0;
                        if (!rx_byte[7]) begin
                            resp    <= rx_byte;
                            timeout <= 1'b0;
                            done    <= 1'b1;
                            state_q <= DONE;
                        end else if (poll_cnt_q == LAST_POLL) begin
                            resp    <= IDLE_BYTE;
                            timeout <= 1'b1;
                            done    <= 1'b1;
                            state_q <= DONE;
                        end else begin
                            poll_cnt_q <= poll_cnt_q + 8'd1;
                        end
                    end
                end

                DONE: begin
                    done    <= 1'b0;
                    busy    <= 1'b0;
                    state_q <= IDLE;
                end

                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sd_cmd_sequencer.sv
// Bench for sd_cmd_sequencer: a byte-engine model with stalls and scripted R1 replies,
// checked against a frame/poll model derived from polynomial division.
module tb_sd_cmd_sequencer;

    localparam int unsigned RESP_TIMEOUT = 8;
    localparam logic [7:0]  POLL_BYTE    = 8'hFF;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [5:0]  cmd_idx;
    logic [31:0] cmd_arg;
    logic        busy;
    logic        done;
    logic [7:0]  resp;
    logic        timeout;
    logic [7:0]  tx_byte;
    logic        tx_valid;
    logic        tx_ready;
    logic [7:0]  rx_byte;
    logic        rx_valid;

    int n_tests = 0;
    int n_fail  = 0;

    logic [7:0] tx_log[$];
    logic [7:0] poll_script[$];
    int         log_base  = 0;
    int         stall_max = 0;
    int         spur_req  = 0;

    always #5 clk = ~clk;

    sd_cmd_sequencer #(
        .RESP_TIMEOUT (RESP_TIMEOUT),
        .POLL_BYTE    (POLL_BYTE)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .cmd_idx  (cmd_idx),
        .cmd_arg  (cmd_arg),
        .busy     (busy),
        .done     (done),
        .resp     (resp),
        .timeout  (timeout),
        .tx_byte  (tx_byte),
        .tx_valid (tx_valid),
        .tx_ready (tx_ready),
        .rx_byte  (rx_byte),
        .rx_valid (rx_valid)
    );

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    // Remainder of msg(x) * x^7 divided by x^7 + x^3 + 1.
    function automatic logic [6:0] crc7_ref(input logic [39:0] msg);
        logic [46:0] r;
        r = {msg, 7'b0};
        for (int i = 46; i >= 7; i--) begin
            if (r[i]) r[i -: 8] = r[i -: 8] ^ 8'h89;
        end
        return r[6:0];
    endfunction

    // Byte engine: one rx per accepted byte, one cycle later; optional tx_ready stalls.
    initial begin : engine
        logic       hs_pend;
        logic [7:0] hs_byte;
        logic       offer_seen;
        logic       prev_stall;
        logic [7:0] prev_byte;
        int         stall_left;
        int         spur_done;
        int         idx;
        hs_pend = 1'b0;  hs_byte = 8'h00; offer_seen = 1'b0;
        prev_stall = 1'b0; prev_byte = 8'h00; stall_left = 0; spur_done = 0;
        rx_valid = 1'b0; rx_byte = 8'hFF; tx_ready = 1'b0;
        forever begin
            @(negedge clk);
            rx_valid = 1'b0;
            if (prev_stall) begin
                check_eq("stall_valid", tx_valid, 1'b1);
                check_eq("stall_byte", tx_byte, prev_byte);
            end
            if (hs_pend) begin
                tx_log.push_back(hs_byte);
                idx = tx_log.size() - 1 - log_base;
                rx_valid = 1'b1;
                if (idx < 6) rx_byte = 8'($urandom);
                else if (idx - 6 < poll_script.size()) rx_byte = poll_script[idx - 6];
                else rx_byte = 8'hFF;
            end else if (spur_done != spur_req) begin
                spur_done = spur_req;
                rx_valid  = 1'b1;
                rx_byte   = 8'h00;
            end
            if (tx_valid && !offer_seen) begin
                offer_seen = 1'b1;
                stall_left = (stall_max == 0) ? 0 : int'($urandom_range(stall_max, 0));
            end
            tx_ready = (stall_left == 0);
            if (stall_left > 0) stall_left--;
            hs_pend = tx_valid && tx_ready;
            if (hs_pend) offer_seen = 1'b0;
            hs_byte    = tx_byte;
            prev_stall = tx_valid && !tx_ready;
            prev_byte  = tx_byte;
        end
    end

    task automatic run_cmd(input string name, input logic [5:0] idx, input logic [31:0] arg,
                           input int stall, input bit mid_start, input bit spur,
                           input int reset_after, input int crc_byte);
        logic [7:0]  exp_tx[$];
        logic [7:0]  exp_resp;
        logic        exp_to;
        logic [7:0]  b;
        logic [39:0] msg;
        int          n_poll;
        int          cyc;
        int          first_valid;
        int          extra_done;
        bit          got_done;

        msg = {2'b01, idx, arg};
        exp_tx.delete();
        for (int i = 4; i >= 0; i--) exp_tx.push_back(msg[i*8 +: 8]);
        exp_tx.push_back({crc7_ref(msg), 1'b1});
        exp_resp = 8'hFF;
        exp_to   = 1'b1;
        n_poll   = RESP_TIMEOUT;
        for (int i = 0; i < RESP_TIMEOUT; i++) begin
            b = (i < poll_script.size()) ? poll_script[i] : 8'hFF;
            if (!b[7]) begin
                exp_resp = b;
                exp_to   = 1'b0;
                n_poll   = i + 1;
                break;
            end
        end
        for (int i = 0; i < n_poll; i++) exp_tx.push_back(POLL_BYTE);

        stall_max = stall;
        cmd_idx = idx;
        cmd_arg = arg;
        start   = 1'b1;
        @(negedge clk);
        start   = 1'b0;
        cmd_idx = ~idx;
        cmd_arg = ~arg;
        check_eq({name, ":busy_on"}, busy, 1'b1);

        cyc = 0; first_valid = -1; got_done = 0;
        while (cyc < 3000) begin
            if (cyc == 20) log_base = tx_log.size();
            if (spur && cyc == 10) spur_req++;
            if (tx_valid && first_valid < 0) first_valid = cyc;
            start = mid_start && first_valid >= 0 && cyc == first_valid + 3;
            if (start) begin
                cmd_idx = idx ^ 6'h2A;
                cmd_arg = arg ^ 32'hDEAD_BEEF;
            end
            if (reset_after > 0 && cyc > 20 && tx_log.size() - log_base >= reset_after) begin
                reset = 1'b1;
                @(negedge clk);
                reset = 1'b0;
                check_eq({name, ":rst_tx_valid"}, tx_valid, 1'b0);
                check_eq({name, ":rst_busy"}, busy, 1'b0);
                check_eq({name, ":rst_resp"}, resp, 8'hFF);
                check_eq({name, ":rst_done"}, done, 1'b0);
                @(negedge clk);
                check_eq({name, ":rst_idle"}, tx_valid, 1'b0);
                return;
            end
            if (done) begin
                got_done = 1;
                break;
            end
            @(negedge clk);
            cyc++;
        end
        start = 1'b0;

        check_eq({name, ":done_seen"}, got_done, 1'b1);
        if (!got_done) begin
            reset = 1'b1;
            @(negedge clk);
            reset = 1'b0;
            return;
        end

        check_eq({name, ":first_valid"}, first_valid, 42);
        check_eq({name, ":busy_done"}, busy, 1'b1);
        check_eq({name, ":resp"}, resp, exp_resp);
        check_eq({name, ":timeout"}, timeout, exp_to);
        check_eq({name, ":tx_count"}, tx_log.size() - log_base, exp_tx.size());
        for (int i = 0; i < exp_tx.size() && log_base + i < tx_log.size(); i++) begin
            check_eq($sformatf("%s:tx%0d", name, i), tx_log[log_base + i], exp_tx[i]);
        end
        if (crc_byte >= 0 && tx_log.size() > log_base + 5)
            check_eq({name, ":crc_byte"}, tx_log[log_base + 5], crc_byte[7:0]);

        // A start during the done cycle must be dropped.
        cmd_idx = 6'h3F;
        start   = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check_eq({name, ":busy_after"}, busy, 1'b0);
        check_eq({name, ":resp_held"}, resp, exp_resp);
        check_eq({name, ":timeout_held"}, timeout, exp_to);
        extra_done = 0;
        for (int i = 0; i < 3; i++) begin
            if (done || busy) extra_done++;
            @(negedge clk);
        end
        check_eq({name, ":done_once"}, extra_done, 0);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got no finish, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset = 1'b1; start = 1'b0; cmd_idx = '0; cmd_arg = '0;
        repeat (3) @(negedge clk);
        check_eq("reset_busy", busy, 1'b0);
        check_eq("reset_done", done, 1'b0);
        check_eq("reset_resp", resp, 8'hFF);
        check_eq("reset_timeout", timeout, 1'b0);
        check_eq("reset_tx_valid", tx_valid, 1'b0);
        check_eq("reset_tx_byte", tx_byte, 8'hFF);
        reset = 1'b0;
        @(negedge clk);
        check_eq("post_reset_tx_valid", tx_valid, 1'b0);

        poll_script = {8'hFF, 8'h01};
        run_cmd("cmd0", 6'd0, 32'h0, 0, 0, 0, 0, 'h95);
        poll_script = {8'h01};
        run_cmd("cmd8", 6'd8, 32'h0000_01AA, 0, 0, 0, 0, 'h87);
        poll_script.delete();
        run_cmd("cmd0_to", 6'd0, 32'h0, 0, 0, 0, 0, 'h95);
        poll_script = {8'h01};
        run_cmd("cmd8_stall", 6'd8, 32'h0000_01AA, 5, 0, 0, 0, 'h87);
        run_cmd("mid_start", 6'd8, 32'h0000_01AA, 0, 1, 0, 0, 'h87);
        run_cmd("spurious_rx", 6'd8, 32'h0000_01AA, 2, 0, 1, 0, 'h87);
        run_cmd("rst_mid", 6'd0, 32'h0, 0, 0, 0, 3, -1);
        poll_script = {8'hFF, 8'h01};
        run_cmd("cmd0_after_rst", 6'd0, 32'h0, 0, 0, 0, 0, 'h95);

        for (int t = 0; t < 16; t++) begin
            int n;
            logic [7:0] rb;
            poll_script.delete();
            n = $urandom_range(10, 0);
            for (int i = 0; i < n; i++) begin
                rb = 8'($urandom);
                rb[7] = ($urandom_range(3, 0) != 0);
                poll_script.push_back(rb);
            end
            run_cmd($sformatf("rnd%0d", t), 6'($urandom), $urandom,
                    $urandom_range(5, 0), $urandom_range(1, 0) == 1,
                    $urandom_range(1, 0) == 1, 0, -1);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
